// File: rtl/top_out_pkg.sv
// Shared constants and the FIFO payload type for the out-packer slice.
package top_out_pkg;
  localparam int SYM_W         = 2;
  localparam int SYMS_PER_WORD = 4;
  localparam int FIFO_DEPTH    = 4;
  localparam int WORD_W        = SYM_W * SYMS_PER_WORD;
  localparam int CNT_W         = $clog2(SYMS_PER_WORD) + 1;
  localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [CNT_W-1:0]  nsym;
    logic              last;
  } word_t;
endpackage

// File: rtl/top_out_fifo.sv
// Synchronous first-word-fall-through FIFO; dout reads 0 while empty.
// Pointers carry an extra wrap bit; push while full is ignored unless a pop frees the slot.
module top_out_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  output logic                     full,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         wr_en, rd_en;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign level = wr_q - rd_q;
  assign dout  = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
    end
  end

  // Storage needs no reset: dout is masked until a word is written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/top_out_packer.sv
// Packs the 2-bit bus_out symbol stream LSB-first into words, buffered in an FWFT FIFO.
// Supports flushing a partial word; a push into a full FIFO without a pop drops the word and sets overflow.
module top_out_packer
  import top_out_pkg::*;
#(
  parameter int SYM_W         = top_out_pkg::SYM_W,
  parameter int SYMS_PER_WORD = top_out_pkg::SYMS_PER_WORD,
  parameter int FIFO_DEPTH    = top_out_pkg::FIFO_DEPTH
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   sym_valid,
  input  logic [SYM_W-1:0]                       sym_data,
  input  logic                                   flush,
  input  logic                                   ovf_clr,
  output logic                                   word_valid,
  output logic [SYM_W*SYMS_PER_WORD-1:0]         word_data,
  output logic [$clog2(SYMS_PER_WORD):0]         word_nsym,
  output logic                                   word_last,
  input  logic                                   word_ready,
  output logic [$clog2(FIFO_DEPTH):0]            fill_level,
  output logic                                   overflow
);
  localparam int WORD_W = SYM_W * SYMS_PER_WORD;
  localparam int CNT_W  = $clog2(SYMS_PER_WORD) + 1;

  logic [WORD_W-1:0] acc_q, acc_d, acc_w;
  logic [CNT_W-1:0]  cnt_q, cnt_d, nsym_w;
  logic              ovf_q, ovf_d;
  logic              full_word_w, push_w, pop_w, drop_w;
  logic              fifo_full, fifo_empty;
  word_t             push_word, head_word;

  always_comb begin
    acc_w = acc_q;
    if (sym_valid) acc_w[cnt_q[CNT_W-2:0]*SYM_W +: SYM_W] = sym_data;
    nsym_w      = cnt_q + CNT_W'(sym_valid);
    full_word_w = sym_valid && (cnt_q == CNT_W'(SYMS_PER_WORD - 1));
    push_w      = full_word_w || (flush && (sym_valid || (cnt_q != '0)));
    pop_w       = !fifo_empty && word_ready;
    drop_w      = push_w && fifo_full && !pop_w;

    push_word.data = acc_w;
    push_word.nsym = nsym_w;
    push_word.last = flush;

    // A push always restarts the packer, even when the word is dropped.
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (push_w) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (sym_valid) begin
      acc_d = acc_w;
      cnt_d = cnt_q + 1'b1;
    end

    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop_w)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  top_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(word_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_w),
    .din   (push_word),
    .full  (fifo_full),
    .pop   (pop_w),
    .dout  (head_word),
    .empty (fifo_empty),
    .level (fill_level)
  );

  assign word_valid = !fifo_empty;
  assign word_data  = head_word.data;
  assign word_nsym  = head_word.nsym;
  assign word_last  = head_word.last;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_top_out_packer.sv
// Directed test-plan sequences plus random traffic, checked every cycle against a queue-based model.
module tb_top_out_packer;
  logic       clk = 1'b0;
  logic       reset, sym_valid, flush, ovf_clr, word_ready;
  logic [1:0] sym_data;
  logic       word_valid, word_last, overflow;
  logic [7:0] word_data;
  logic [2:0] word_nsym, fill_level;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int data;
    int nsym;
    bit last;
  } mword_t;

  int     pend[$];
  mword_t mq[$];
  bit     movf;

  always #5 clk = ~clk;

  top_out_packer dut (
    .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym_data(sym_data),
    .flush(flush), .ovf_clr(ovf_clr), .word_valid(word_valid), .word_data(word_data),
    .word_nsym(word_nsym), .word_last(word_last), .word_ready(word_ready),
    .fill_level(fill_level), .overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: pending symbols as a list, words as a bounded queue of 4.
  task automatic model_step(input bit rst, input bit sv, input int sd, input bit fl,
                            input bit oc, input bit rdy);
    bit     pop, push;
    mword_t w;
    if (rst) begin
      pend.delete();
      mq.delete();
      movf = 0;
      return;
    end
    pop = (mq.size() > 0) && rdy;
    if (sv) pend.push_back(sd);
    push = (sv && pend.size() == 4) || (fl && pend.size() > 0);
    if (push) begin
      w.data = 0;
      foreach (pend[i]) w.data += pend[i] * (1 << (2 * i));
      w.nsym = pend.size();
      w.last = fl;
      pend.delete();
    end
    if (oc) movf = 0;
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < 4) mq.push_back(w);
      else movf = 1;
    end
  endtask

  task automatic compare_all();
    check("word_valid", word_valid, mq.size() > 0);
    check("fill_level", fill_level, mq.size());
    check("overflow", overflow, movf);
    if (mq.size() > 0) begin
      check("word_data", word_data, mq[0].data);
      check("word_nsym", word_nsym, mq[0].nsym);
      check("word_last", word_last, mq[0].last);
    end else begin
      check("empty_data", word_data, 0);
      check("empty_nsym", word_nsym, 0);
      check("empty_last", word_last, 0);
    end
  endtask

  task automatic cyc(input bit rst, input bit sv, input int sd, input bit fl,
                     input bit oc, input bit rdy);
    reset = rst; sym_valid = sv; sym_data = 2'(sd); flush = fl;
    ovf_clr = oc; word_ready = rdy;
    model_step(rst, sv, sd, fl, oc, rdy);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic sym(input int sd, input bit rdy);
    cyc(0, 1, sd, 0, 0, rdy);
  endtask

  task automatic idle(input bit rdy);
    cyc(0, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    int plan [4] = '{1, 2, 3, 0};
    reset = 1; sym_valid = 0; sym_data = 0; flush = 0; ovf_clr = 0; word_ready = 0;
    cyc(1, 0, 0, 0, 0, 0);
    check("rst_valid", word_valid, 0);
    check("rst_level", fill_level, 0);

    // Full word 1,2,3,0
    foreach (plan[i]) sym(plan[i], 1);
    check("full_word_data", word_data, 8'h39);
    check("full_word_nsym", word_nsym, 4);
    check("full_word_last", word_last, 0);
    idle(1);

    // Partial flush, then lone flush
    sym(3, 1); sym(1, 1);
    cyc(0, 0, 0, 1, 0, 1);
    check("flush_data", word_data, 8'h07);
    check("flush_nsym", word_nsym, 2);
    check("flush_last", word_last, 1);
    idle(1);
    cyc(0, 0, 0, 1, 0, 1);
    check("lone_flush_valid", word_valid, 0);

    // Flush coinciding with third symbol
    sym(1, 1); sym(1, 1);
    cyc(0, 1, 2, 1, 0, 1);
    check("coinc_data", word_data, 8'h25);
    check("coinc_nsym", word_nsym, 3);
    check("coinc_last", word_last, 1);
    idle(1);

    // Overflow: 5 words with no ready
    for (int i = 0; i < 20; i++) sym($urandom_range(0, 3), 0);
    check("ovf_level", fill_level, 4);
    check("ovf_flag", overflow, 1);
    for (int i = 0; i < 4; i++) idle(1);
    cyc(0, 0, 0, 0, 1, 0);
    check("ovf_clr", overflow, 0);

    // Full FIFO with a pop on the cycle the 5th word completes
    for (int i = 0; i < 19; i++) sym($urandom_range(0, 3), 0);
    sym($urandom_range(0, 3), 1);
    check("poppush_level", fill_level, 4);
    check("poppush_ovf", overflow, 0);
    for (int i = 0; i < 5; i++) idle(1);

    // Reset with cnt=2 and 3 words queued
    for (int i = 0; i < 14; i++) sym($urandom_range(0, 3), 0);
    check("pre_rst_level", fill_level, 3);
    cyc(1, 0, 0, 0, 0, 0);
    check("rst2_valid", word_valid, 0);
    check("rst2_data", word_data, 0);
    check("rst2_level", fill_level, 0);
    foreach (plan[i]) sym(plan[i], 0);
    check("post_rst_data", word_data, 8'h39);
    idle(1);

    // Random traffic, alternating heavy and light backpressure
    for (int i = 0; i < 3000; i++) begin
      bit hold = ((i / 200) % 2) == 1;
      cyc(($urandom_range(0, 599) == 0),
          ($urandom_range(0, 3) != 0),
          $urandom_range(0, 3),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 15) == 0),
          hold ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
